// File: rtl/output_port_demux_pkg.sv
// output_port_demux_pkg: shared constants, FSM states and destination mask helper
package output_port_demux_pkg;

    localparam logic [7:0] IOQ_CTRL         = 8'hFF;
    localparam int         IOQ_DST_PORT_POS = 48;
    localparam int         NUM_OUT_PORTS    = 4;

    typedef enum logic [1:0] {
        ST_SOP,
        ST_HDR,
        ST_PAYLOAD
    } state_e;

    // Only even destination bits 0,2,4,6 map to physical ports; the rest are ignored.
    function automatic logic [NUM_OUT_PORTS-1:0] port_mask(input logic [15:0] dst);
        return {dst[6], dst[4], dst[2], dst[0]};
    endfunction

endpackage

// File: rtl/output_port_demux_if.sv
// output_port_demux_if: merged input stream plus the four even-numbered output ports
interface output_port_demux_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  in_wr;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] out_data_0, out_data_2, out_data_4, out_data_6;
    logic [CTRL_WIDTH-1:0] out_ctrl_0, out_ctrl_2, out_ctrl_4, out_ctrl_6;
    logic                  out_wr_0, out_wr_2, out_wr_4, out_wr_6;
    logic                  out_rdy_0, out_rdy_2, out_rdy_4, out_rdy_6;

    modport slave (
        input  in_data, in_ctrl, in_wr,
        output in_rdy,
        output out_data_0, out_data_2, out_data_4, out_data_6,
        output out_ctrl_0, out_ctrl_2, out_ctrl_4, out_ctrl_6,
        output out_wr_0, out_wr_2, out_wr_4, out_wr_6,
        input  out_rdy_0, out_rdy_2, out_rdy_4, out_rdy_6
    );

    modport master (
        output in_data, in_ctrl, in_wr,
        input  in_rdy,
        input  out_data_0, out_data_2, out_data_4, out_data_6,
        input  out_ctrl_0, out_ctrl_2, out_ctrl_4, out_ctrl_6,
        input  out_wr_0, out_wr_2, out_wr_4, out_wr_6,
        output out_rdy_0, out_rdy_2, out_rdy_4, out_rdy_6
    );

endinterface

// File: rtl/output_port_demux_out_reg.sv
// demux_out_reg: single shared output register with lockstep multicast drain
module demux_out_reg
    import output_port_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic                     eop_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic [CTRL_WIDTH-1:0]    ctrl_i,
    input  logic [NUM_OUT_PORTS-1:0] mask_i,
    input  logic [NUM_OUT_PORTS-1:0] out_rdy_i,
    output logic                     rdy_o,
    output logic                     advance_o,
    output logic                     eop_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic [CTRL_WIDTH-1:0]    ctrl_o,
    output logic [NUM_OUT_PORTS-1:0] wr_o
);
    logic                     valid_q, valid_d, eop_q, eop_d;
    logic [NUM_OUT_PORTS-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [CTRL_WIDTH-1:0]    ctrl_q, ctrl_d;

    // Drain only when every selected port is ready, so all copies leave together.
    always_comb begin
        advance_o = valid_q & ((mask_q & ~out_rdy_i) == '0);
        wr_o      = advance_o ? mask_q : '0;
        rdy_o     = ~valid_q | advance_o;
        valid_d   = load_i | (valid_q & ~advance_o);
        mask_d    = load_i ? mask_i : mask_q;
        eop_d     = load_i ? eop_i : eop_q;
        data_d    = load_i ? data_i : data_q;
        ctrl_d    = load_i ? ctrl_i : ctrl_q;
    end

    // Register stage state; contents persist after draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            mask_q  <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            eop_q   <= eop_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign eop_o  = eop_q;
    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/output_port_demux.sv
// output_port_demux: frames the merged stream and multicasts packets to ports 0/2/4/6
module output_port_demux
    import output_port_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output_port_demux_if.slave   bus,
    output logic [CNT_WIDTH-1:0] num_pkts_fwd,
    output logic [CNT_WIDTH-1:0] num_pkts_drop
);
    state_e                   state_q, state_d;
    logic [NUM_OUT_PORTS-1:0] mask_q, mask_d, sop_mask, cur_mask, reg_wr, out_rdy;
    logic                     drop_q, drop_d, sop, sop_bad, cur_drop, is_eop, accept, load;
    logic                     in_rdy, advance, reg_eop;
    logic [CNT_WIDTH-1:0]     fwd_q, fwd_d, drp_q, drp_d;
    logic [DATA_WIDTH-1:0]    reg_data;
    logic [CTRL_WIDTH-1:0]    reg_ctrl;

    assign out_rdy = {bus.out_rdy_6, bus.out_rdy_4, bus.out_rdy_2, bus.out_rdy_0};

    // Framing FSM, per-packet mask/drop decision and counter next-state.
    always_comb begin
        accept   = bus.in_wr & in_rdy;
        sop      = state_q == ST_SOP;
        sop_mask = port_mask(bus.in_data[IOQ_DST_PORT_POS +: 16]);
        sop_bad  = (bus.in_ctrl != CTRL_WIDTH'(IOQ_CTRL)) | (sop_mask == '0);
        cur_drop = sop ? sop_bad : drop_q;
        cur_mask = sop ? sop_mask : mask_q;
        is_eop   = (state_q == ST_PAYLOAD) & (bus.in_ctrl != '0);
        load     = accept & ~cur_drop;
        state_d  = !accept ? state_q :
                   sop ? ST_HDR :
                   (state_q == ST_HDR && bus.in_ctrl == '0) ? ST_PAYLOAD :
                   is_eop ? ST_SOP : state_q;
        mask_d   = (accept & sop) ? sop_mask : mask_q;
        drop_d   = (accept & sop) ? sop_bad : drop_q;
        drp_d    = (accept & is_eop & cur_drop & ~&drp_q) ? drp_q + 1'b1 : drp_q;
        fwd_d    = fwd_q + CNT_WIDTH'(advance & reg_eop);
    end

    // FSM, latched packet attributes and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SOP;
            mask_q  <= '0;
            drop_q  <= 1'b0;
            fwd_q   <= '0;
            drp_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            drop_q  <= drop_d;
            fwd_q   <= fwd_d;
            drp_q   <= drp_d;
        end
    end

    demux_out_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .CTRL_WIDTH(CTRL_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .eop_i    (is_eop),
        .data_i   (bus.in_data),
        .ctrl_i   (bus.in_ctrl),
        .mask_i   (cur_mask),
        .out_rdy_i(out_rdy),
        .rdy_o    (in_rdy),
        .advance_o(advance),
        .eop_o    (reg_eop),
        .data_o   (reg_data),
        .ctrl_o   (reg_ctrl),
        .wr_o     (reg_wr)
    );

    assign bus.in_rdy     = in_rdy;
    assign bus.out_data_0 = reg_data;
    assign bus.out_data_2 = reg_data;
    assign bus.out_data_4 = reg_data;
    assign bus.out_data_6 = reg_data;
    assign bus.out_ctrl_0 = reg_ctrl;
    assign bus.out_ctrl_2 = reg_ctrl;
    assign bus.out_ctrl_4 = reg_ctrl;
    assign bus.out_ctrl_6 = reg_ctrl;
    assign bus.out_wr_0   = reg_wr[0];
    assign bus.out_wr_2   = reg_wr[1];
    assign bus.out_wr_4   = reg_wr[2];
    assign bus.out_wr_6   = reg_wr[3];
    assign num_pkts_fwd   = fwd_q;
    assign num_pkts_drop  = drp_q;

endmodule

// File: tb/tb_output_port_demux.sv
// tb_output_port_demux: directed and random packets checked against a packet-level model
module tb_output_port_demux;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    output_port_demux_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) ifm ();
    output_port_demux_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) ifs ();

    logic [15:0] fwd, drop;
    logic [3:0]  fwd_s, drop_s;

    output_port_demux #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(ifm.slave), .num_pkts_fwd(fwd), .num_pkts_drop(drop)
    );

    // Narrow-counter copy sharing the same stimulus, to reach saturation quickly.
    output_port_demux #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .bus(ifs.slave), .num_pkts_fwd(fwd_s), .num_pkts_drop(drop_s)
    );

    assign ifs.in_data   = ifm.in_data;
    assign ifs.in_ctrl   = ifm.in_ctrl;
    assign ifs.in_wr     = ifm.in_wr;
    assign ifs.out_rdy_0 = ifm.out_rdy_0;
    assign ifs.out_rdy_2 = ifm.out_rdy_2;
    assign ifs.out_rdy_4 = ifm.out_rdy_4;
    assign ifs.out_rdy_6 = ifm.out_rdy_6;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic [3:0]  m;
        bit          eop;
    } word_t;

    word_t      q[$];
    int         phase = 0;
    logic [3:0] pkt_m = '0;
    bit         pkt_drop = 1'b0;
    int         exp_fwd = 0, exp_drop = 0;
    int         passed = 0, failed = 0, total = 0, cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [63:0] d, input logic [7:0] c);
        bit eop;
        eop = (phase == 2) && (c != 0);
        if (phase == 0) begin
            pkt_m    = {d[54], d[52], d[50], d[48]};
            pkt_drop = (c != 8'hFF) || (pkt_m == 0);
        end
        if (!pkt_drop) q.push_back('{d, c, pkt_m, eop});
        else if (eop) exp_drop++;
        phase = (phase == 0) ? 1 : (phase == 1 && c == 0) ? 2 : eop ? 0 : phase;
    endtask

    task automatic cycle(input bit w, input logic [63:0] d, input logic [7:0] c,
                         input logic [3:0] rdy, input bit r, output bit acc);
        bit          drain;
        logic [3:0]  exp_wr;
        logic [63:0] pd[4];
        logic [7:0]  pc[4];
        ifm.in_wr   = w;
        ifm.in_data = d;
        ifm.in_ctrl = c;
        {ifm.out_rdy_6, ifm.out_rdy_4, ifm.out_rdy_2, ifm.out_rdy_0} = rdy;
        reset = r;
        @(negedge clk);
        cyc++;
        drain  = (q.size() > 0) && ((q[0].m & ~rdy) == 0);
        exp_wr = drain ? q[0].m : 4'b0;
        check("out_wr", {ifm.out_wr_6, ifm.out_wr_4, ifm.out_wr_2, ifm.out_wr_0}, exp_wr);
        check("in_rdy", ifm.in_rdy, (q.size() == 0) || drain);
        check("num_pkts_fwd", fwd, exp_fwd % 65536);
        check("num_pkts_drop", drop, (exp_drop > 65535) ? 65535 : exp_drop);
        check("fwd_narrow", fwd_s, exp_fwd % 16);
        check("drop_narrow", drop_s, (exp_drop > 15) ? 15 : exp_drop);
        if (drain) begin
            pd = '{ifm.out_data_0, ifm.out_data_2, ifm.out_data_4, ifm.out_data_6};
            pc = '{ifm.out_ctrl_0, ifm.out_ctrl_2, ifm.out_ctrl_4, ifm.out_ctrl_6};
            for (int i = 0; i < 4; i++)
                if (q[0].m[i]) begin
                    check("out_data", pd[i], q[0].d);
                    check("out_ctrl", pc[i], q[0].c);
                end
        end
        acc = w && ((q.size() == 0) || drain);
        if (r) begin
            q.delete();
            phase    = 0;
            exp_fwd  = 0;
            exp_drop = 0;
        end else begin
            if (drain) begin
                if (q[0].eop) exp_fwd++;
                void'(q.pop_front());
            end
            if (acc) model_accept(d, c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, 8'h0, 4'hF, 1'b0, acc);
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] c, input bit rm);
        bit         acc;
        int         n;
        logic [3:0] rdy;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            for (int i = 0; i < 4; i++) rdy[i] = rm ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rm && $urandom_range(0, 4) == 0) cycle(1'b0, d, c, rdy, 1'b0, acc);
            else cycle(1'b1, d, c, rdy, 1'b0, acc);
            n++;
        end
        check("word_accepted_in_bound", acc, 1'b1);
    endtask

    task automatic send_pkt(input logic [15:0] m, input logic [7:0] sc,
                            input int nh, input int np, input bit rm);
        logic [63:0] sop;
        sop = {$urandom, $urandom};
        sop[63:48] = m;
        send_word(sop, sc, rm);
        for (int i = 0; i < nh; i++) send_word({$urandom, $urandom}, 8'($urandom_range(1, 255)), rm);
        for (int i = 0; i < np; i++) send_word({$urandom, $urandom}, 8'h00, rm);
        send_word({$urandom, $urandom}, 8'($urandom_range(1, 255)), rm);
    endtask

    initial begin
        bit          acc;
        int          c0, f0;
        logic [63:0] w1;
        ifm.in_wr   = 1'b0;
        ifm.in_data = '0;
        ifm.in_ctrl = '0;
        {ifm.out_rdy_6, ifm.out_rdy_4, ifm.out_rdy_2, ifm.out_rdy_0} = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_data", ifm.out_data_4, 64'h0);
        check("rst_ctrl", ifm.out_ctrl_6, 8'h0);
        @(posedge clk);
        #1;
        idle(2);

        send_pkt(16'h0004, 8'hFF, 0, 2, 1'b0);
        idle(2);
        check("unicast_fwd", fwd, 16'd1);

        w1 = {$urandom, $urandom};
        cycle(1'b1, {16'h0055, 48'h0123_4567_89AB}, 8'hFF, 4'hF, 1'b0, acc);
        for (int i = 0; i < 3; i++) cycle(1'b1, w1, 8'h00, 4'b1011, 1'b0, acc);
        send_word(w1, 8'h00, 1'b0);
        send_word({$urandom, $urandom}, 8'h04, 1'b0);
        idle(2);
        check("multicast_fwd", fwd, 16'd2);

        send_pkt(16'h00AA, 8'hFF, 1, 1, 1'b0);
        send_pkt(16'h0004, 8'h01, 0, 1, 1'b0);
        idle(2);
        check("drop_count", drop, 16'd2);

        c0 = cyc;
        f0 = exp_fwd;
        for (int p = 0; p < 10; p++) send_pkt((p % 2) ? 16'h0040 : 16'h0001, 8'hFF, 0, 2, 1'b0);
        check("b2b_cycles", cyc - c0, 40);
        idle(2);
        check("b2b_fwd", fwd, 16'(f0 + 10));

        send_word({16'h0001, 48'h0}, 8'hFF, 1'b0);
        send_word({$urandom, $urandom}, 8'h00, 1'b0);
        cycle(1'b0, 64'h0, 8'h0, 4'hF, 1'b1, acc);
        check("mid_rst_data", ifm.out_data_0, 64'h0);
        check("mid_rst_fwd", fwd, 16'h0);
        send_word({$urandom, $urandom}, 8'h00, 1'b0);
        send_word({$urandom, $urandom}, 8'h00, 1'b0);
        send_word({$urandom, $urandom}, 8'h30, 1'b0);
        idle(2);
        check("mid_rst_drop", drop, 16'd1);

        for (int p = 0; p < 40; p++)
            send_pkt(16'($urandom), ($urandom_range(0, 7) == 0) ? 8'h01 : 8'hFF,
                     $urandom_range(0, 2), $urandom_range(1, 4), 1'b1);
        idle(3);

        for (int p = 0; p < 20; p++) send_pkt(16'h0000, 8'hFF, 0, 1, 1'b0);
        idle(2);
        check("drop_saturated", drop_s, 4'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
